// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg -- shared definitions for the 8-bit stack-machine processor.
//   * default parameter values used by cpu, ifidc, memory and cpu_if
//   * instruction field positions: {opcode[11:8], operand[7:0]}
//   * 4-bit opcode enumeration
//   * in_range(): unsigned bound check used for fetch and data addresses
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam int DEF_WORD_LEN    = 8;
    localparam int DEF_DATA_LEN    = 8;
    localparam int DEF_ADDR_LEN    = 8;
    localparam int DEF_MEM_SIZE    = 256;
    localparam int DEF_STACK_DEPTH = 8;
    localparam int DEF_INST_LEN    = 12;
    localparam int DEF_INST_CAP    = 20;

    localparam int OPC_MSB = 11;
    localparam int OPC_LSB = 8;
    localparam int OPR_MSB = 7;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_PUSH  = 4'h1,
        OP_LOAD  = 4'h2,
        OP_STORE = 4'h3,
        OP_ADD   = 4'h4,
        OP_SUB   = 4'h5,
        OP_AND   = 4'h6,
        OP_OR    = 4'h7,
        OP_XOR   = 4'h8,
        OP_NOT   = 4'h9,
        OP_DUP   = 4'hA,
        OP_JMP   = 4'hB,
        OP_JZ    = 4'hC,
        OP_JNZ   = 4'hD,
        OP_RSV   = 4'hE,
        OP_HALT  = 4'hF
    } opcode_e;

    // Done at 32 bits so a bound equal to 2^width never folds to a constant.
    function automatic logic in_range(input int a, input int size);
        return a < size;
    endfunction

endpackage

// File: rtl/cpu_if.sv
// ----------------------------------------------------------------------------
// cpu_if -- data-memory bus between the processor core and its data memory.
//   addr  : word address
//   wdata : store data
//   we    : write strobe, sampled on the rising clock edge
//   rdata : combinational read data for addr (0 when addr is out of range)
// Modports: master (core side), slave (memory side).
// ----------------------------------------------------------------------------
interface cpu_if
    import cpu_pkg::*;
#(
    parameter int ADDR_LEN = DEF_ADDR_LEN,
    parameter int WORD_LEN = DEF_WORD_LEN
);
    logic [ADDR_LEN-1:0] addr;
    logic [WORD_LEN-1:0] wdata;
    logic [WORD_LEN-1:0] rdata;
    logic                we;

    modport master (output addr, output wdata, output we, input rdata);
    modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/ifidc.sv
// ----------------------------------------------------------------------------
// ifidc -- instruction store, program counter, decode and run control.
//   clk, rstn : clock, asynchronous active-low reset
//   fault     : current instruction hit a stack error (guard builds only)
//   top_zero  : stack top is zero (JZ/JNZ condition)
//   opc, opr  : decoded opcode and operand of the instruction at pc
//   exec      : an instruction executes on the next rising edge
// Internal state: inst_mem (preloaded by the bench, never reset), pc,
// halted, stack_err.
// ----------------------------------------------------------------------------
module ifidc
    import cpu_pkg::*;
#(
    parameter int ADDR_LEN = DEF_ADDR_LEN,
    parameter int INST_LEN = DEF_INST_LEN,
    parameter int INST_CAP = DEF_INST_CAP
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                fault,
    input  logic                top_zero,
    output opcode_e             opc,
    output logic [ADDR_LEN-1:0] opr,
    output logic                exec
);
    localparam int PCW = (INST_CAP > 1) ? $clog2(INST_CAP) : 1;

    logic [INST_LEN-1:0] inst_mem [0:INST_CAP-1];
    logic [INST_LEN-1:0] inst;
    logic [ADDR_LEN-1:0] pc;
    logic [ADDR_LEN-1:0] pc_inc;
    logic                halted;
    logic                stack_err;
    logic                fetch_ok;

    assign fetch_ok = in_range(32'(pc), INST_CAP);
    assign inst     = fetch_ok ? inst_mem[PCW'(pc)] : '0;
    assign opc      = opcode_e'(inst[OPC_MSB:OPC_LSB]);
    assign opr      = inst[OPR_MSB:0];
    assign exec     = !halted && fetch_ok;
    assign pc_inc   = pc + ADDR_LEN'(1);

    // NOTE: reset sits in the sensitivity list so rstn low clears control
    // state immediately, without waiting for a clock edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc        <= '0;
            halted    <= 1'b0;
            stack_err <= 1'b0;
        end else if (!halted && !stack_err) begin
            if (!fetch_ok) begin
                halted <= 1'b1;
            end else if (fault) begin
                // Faulting instruction leaves pc pointing at itself.
                halted    <= 1'b1;
                stack_err <= 1'b1;
            end else begin
                case (opc)
                    OP_JMP:  pc <= opr;
                    OP_JZ:   pc <= top_zero ? opr : pc_inc;
                    OP_JNZ:  pc <= top_zero ? pc_inc : opr;
                    OP_HALT: begin
                        halted <= 1'b1;
                        pc     <= pc_inc;
                    end
                    default: pc <= pc_inc;
                endcase
            end
        end
    end
endmodule

// File: rtl/memory.sv
// ----------------------------------------------------------------------------
// memory -- data memory, MEM_SIZE words of WORD_LEN bits.
//   clk : write clock
//   bus : cpu_if slave; combinational read, synchronous write
// Addresses >= MEM_SIZE read as 0 and writes to them are dropped.
// ----------------------------------------------------------------------------
module memory
    import cpu_pkg::*;
#(
    parameter int WORD_LEN = DEF_WORD_LEN,
    parameter int ADDR_LEN = DEF_ADDR_LEN,
    parameter int MEM_SIZE = DEF_MEM_SIZE
) (
    input logic   clk,
    cpu_if.slave  bus
);
    logic [WORD_LEN-1:0] mem [0:MEM_SIZE-1];
    logic                addr_ok;

    assign addr_ok   = in_range(32'(bus.addr), MEM_SIZE);
    assign bus.rdata = addr_ok ? mem[bus.addr] : '0;

    // NOTE: the array has no reset so preloaded contents survive rstn;
    // non-blocking write keeps a same-edge read returning the old word.
    always_ff @(posedge clk) begin
        if (bus.we && addr_ok) begin
            mem[bus.addr] <= bus.wdata;
        end
    end
endmodule

// File: rtl/cpu.sv
// ----------------------------------------------------------------------------
// cpu -- single-cycle 8-bit stack-machine processor (top level).
//   clk  : rising-edge clock
//   rstn : asynchronous active-low reset
// Holds the operand stack and ALU; instantiates ifidc0 (fetch/decode/pc) and
// memory0 (data memory). One instruction completes per clock.
// Build option: CPU_STACK_GUARD_EN -- stack errors halt with stack_err set.
// Without it, pushes on a full stack are dropped and missing operands read 0.
// ----------------------------------------------------------------------------
module cpu
    import cpu_pkg::*;
#(
    parameter int WORD_LEN    = DEF_WORD_LEN,
    parameter int DATA_LEN    = DEF_DATA_LEN,
    parameter int ADDR_LEN    = DEF_ADDR_LEN,
    parameter int MEM_SIZE    = DEF_MEM_SIZE,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH,
    parameter int INST_LEN    = DEF_INST_LEN,
    parameter int INST_CAP    = DEF_INST_CAP
) (
    input logic clk,
    input logic rstn
);
    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    cpu_if #(.ADDR_LEN(ADDR_LEN), .WORD_LEN(WORD_LEN)) dbus ();

    opcode_e             opc;
    logic [ADDR_LEN-1:0] opr;
    logic                exec, fault, commit, top_zero;

    logic [DATA_LEN-1:0] stk [0:STACK_DEPTH-1];
    logic [SPW-1:0]      sp, sp_pop, sp_next;
    logic [DATA_LEN-1:0] a_val, b_val, push_val;
    logic [1:0]          pops;
    logic                do_push, room;

    ifidc #(.ADDR_LEN(ADDR_LEN), .INST_LEN(INST_LEN), .INST_CAP(INST_CAP)) ifidc0 (
        .clk      (clk),
        .rstn     (rstn),
        .fault    (fault),
        .top_zero (top_zero),
        .opc      (opc),
        .opr      (opr),
        .exec     (exec)
    );

    memory #(.WORD_LEN(WORD_LEN), .ADDR_LEN(ADDR_LEN), .MEM_SIZE(MEM_SIZE)) memory0 (
        .clk (clk),
        .bus (dbus)
    );

    // b is the top entry, a the one below; absent entries read as 0.
    assign b_val = (sp >= SPW'(1)) ? stk[IW'(sp - SPW'(1))] : '0;
    assign a_val = (sp >= SPW'(2)) ? stk[IW'(sp - SPW'(2))] : '0;

    // NOTE: every output gets a default before the case so no latch forms.
    always_comb begin
        pops     = 2'd0;
        do_push  = 1'b0;
        push_val = b_val;
        case (opc)
            OP_PUSH:  begin do_push = 1'b1; push_val = DATA_LEN'(opr); end
            OP_LOAD:  begin do_push = 1'b1; push_val = dbus.rdata; end
            OP_STORE,
            OP_JZ,
            OP_JNZ:   pops = 2'd1;
            OP_ADD:   begin pops = 2'd2; do_push = 1'b1; push_val = a_val + b_val; end
            OP_SUB:   begin pops = 2'd2; do_push = 1'b1; push_val = a_val - b_val; end
            OP_AND:   begin pops = 2'd2; do_push = 1'b1; push_val = a_val & b_val; end
            OP_OR:    begin pops = 2'd2; do_push = 1'b1; push_val = a_val | b_val; end
            OP_XOR:   begin pops = 2'd2; do_push = 1'b1; push_val = a_val ^ b_val; end
            OP_NOT:   begin pops = 2'd1; do_push = 1'b1; push_val = ~b_val; end
            OP_DUP:   do_push = 1'b1;
            default:  ;
        endcase
    end

    // Pops saturate at empty; a push only lands if the popped stack has room.
    assign sp_pop  = (sp >= SPW'(pops)) ? sp - SPW'(pops) : '0;
    assign room    = sp_pop < SPW'(STACK_DEPTH);
    assign sp_next = sp_pop + SPW'(do_push && room);

`ifdef CPU_STACK_GUARD_EN
    logic [1:0] need;
    // DUP consumes nothing but still needs a top entry to copy.
    assign need  = (opc == OP_DUP) ? 2'd1 : pops;
    assign fault = exec && ((sp < SPW'(need)) || (do_push && !room));
`else
    assign fault = 1'b0;
`endif

    assign commit   = exec && !fault;
    assign top_zero = (b_val == '0);

    assign dbus.addr  = opr;
    assign dbus.wdata = b_val;
    assign dbus.we    = commit && (opc == OP_STORE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sp <= '0;
        end else if (commit) begin
            sp <= sp_next;
        end
    end

    always_ff @(posedge clk) begin
        if (commit && do_push && room) begin
            stk[IW'(sp_pop)] <= push_val;
        end
    end
endmodule

// File: tb/tb_cpu.sv
// ----------------------------------------------------------------------------
// tb_cpu -- self-checking bench for cpu. Programs are written straight into
// ifidc0.inst_mem; a monitor on a cpu_if copy of the data bus checks every
// store against a queue of expected writes. Binary/unary ops come from a
// vector table; the loop, reset, stack-overflow and fetch-bound cases are
// hand-written sequences.
// ----------------------------------------------------------------------------
module tb_cpu;
    import cpu_pkg::*;

    logic clk  = 1'b0;
    logic rstn = 1'b1;

    always #5 clk = ~clk;

    cpu dut (.clk(clk), .rstn(rstn));

    cpu_if mon ();
    assign mon.addr  = dut.dbus.addr;
    assign mon.wdata = dut.dbus.wdata;
    assign mon.we    = dut.dbus.we;
    assign mon.rdata = dut.dbus.rdata;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        opcode_e    op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        int         sp_end;
    } vec_t;

    wr_t  exp_q[$];
    vec_t vecs[9];
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard: a store is on the bus half a cycle before it commits.
    always @(negedge clk) begin : sb
        wr_t e;
        if (rstn && mon.we) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_write_addr", {24'h0, mon.addr}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("sb_addr", {24'h0, mon.addr}, {24'h0, e.addr});
                check("sb_data", {24'h0, mon.wdata}, {24'h0, e.data});
            end
        end
    end

    function automatic logic [11:0] ins(input opcode_e op, input logic [7:0] v);
        return {op, v};
    endfunction

    task automatic fill(input logic [11:0] w);
        for (int i = 0; i < 20; i++) dut.ifidc0.inst_mem[i] = w;
    endtask

    task automatic put(input int a, input opcode_e op, input logic [7:0] v);
        dut.ifidc0.inst_mem[a] = ins(op, v);
    endtask

    task automatic expect_wr(input logic [7:0] a, input logic [7:0] d);
        exp_q.push_back('{addr: a, data: d});
    endtask

    // Leaves rstn high 1 ns after a falling edge; pc=0 runs on the next rise.
    task automatic reset_dut();
        rstn = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic run(input int budget, output int cycles);
        cycles = 0;
        while (!dut.ifidc0.halted && cycles < budget) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic load_loop();
        fill(ins(OP_HALT, 8'h00));
        put(0, OP_PUSH, 8'd3);
        put(1, OP_STORE, 8'd2);
        put(2, OP_LOAD, 8'd2);
        put(3, OP_PUSH, 8'd1);
        put(4, OP_SUB, 8'd0);
        put(5, OP_DUP, 8'd0);
        put(6, OP_JNZ, 8'd1);
        put(7, OP_STORE, 8'd2);
        put(8, OP_HALT, 8'd0);
    endtask

    task automatic expect_loop();
        expect_wr(8'd2, 8'd3);
        expect_wr(8'd2, 8'd2);
        expect_wr(8'd2, 8'd1);
        expect_wr(8'd2, 8'd0);
    endtask

    initial begin
        vecs[0] = '{OP_ADD, 8'h05, 8'h03, 8'h08, 0};
        vecs[1] = '{OP_ADD, 8'hFF, 8'h02, 8'h01, 0};
        vecs[2] = '{OP_SUB, 8'hF0, 8'h20, 8'hD0, 0};
        vecs[3] = '{OP_SUB, 8'h01, 8'h02, 8'hFF, 0};
        vecs[4] = '{OP_AND, 8'hCC, 8'hAA, 8'h88, 0};
        vecs[5] = '{OP_OR,  8'hCC, 8'hAA, 8'hEE, 0};
        vecs[6] = '{OP_XOR, 8'hCC, 8'hAA, 8'h66, 0};
        vecs[7] = '{OP_NOT, 8'h12, 8'h0F, 8'hF0, 1};
        vecs[8] = '{OP_DUP, 8'h11, 8'h22, 8'h22, 2};

        // Reset state while rstn is held low.
        #1 rstn = 1'b0;
        #2;
        check("rst_pc", 32'(dut.ifidc0.pc), 0);
        check("rst_sp", 32'(dut.sp), 0);
        check("rst_halted", 32'(dut.ifidc0.halted), 0);
        check("rst_stack_err", 32'(dut.ifidc0.stack_err), 0);

        // Table: PUSH a, PUSH b, op, STORE 0x40, HALT.
        for (int i = 0; i < 9; i++) begin
            reset_dut();
            fill(ins(OP_HALT, 8'h00));
            put(0, OP_PUSH, vecs[i].a);
            put(1, OP_PUSH, vecs[i].b);
            put(2, vecs[i].op, 8'h00);
            put(3, OP_STORE, 8'h40);
            put(4, OP_HALT, 8'h00);
            expect_wr(8'h40, vecs[i].res);
            run(20, cyc);
            check($sformatf("vec%0d_cycles", i), 32'(cyc), 5);
            check($sformatf("vec%0d_mem", i), 32'(dut.memory0.mem[8'h40]), 32'(vecs[i].res));
            check($sformatf("vec%0d_sp", i), 32'(dut.sp), 32'(vecs[i].sp_end));
            check($sformatf("vec%0d_halted", i), 32'(dut.ifidc0.halted), 1);
            check($sformatf("vec%0d_sb_drain", i), 32'(exp_q.size()), 0);
        end

        // Preloaded data, LOAD/SUB/STORE, then wrap-around subtraction.
        reset_dut();
        dut.memory0.mem[0] = 8'hF0;
        fill(ins(OP_HALT, 8'h00));
        put(0, OP_LOAD, 8'h00);
        put(1, OP_PUSH, 8'h20);
        put(2, OP_SUB, 8'h00);
        put(3, OP_STORE, 8'h01);
        put(4, OP_PUSH, 8'h01);
        put(5, OP_PUSH, 8'h02);
        put(6, OP_SUB, 8'h00);
        put(7, OP_HALT, 8'h00);
        expect_wr(8'h01, 8'hD0);
        run(30, cyc);
        check("load_mem1", 32'(dut.memory0.mem[1]), 32'hD0);
        check("wrap_top", 32'(dut.stk[0]), 32'hFF);
        check("wrap_sp", 32'(dut.sp), 1);
        check("load_cycles", 32'(cyc), 8);

        // JZ taken skips the 0xAA store.
        reset_dut();
        fill(ins(OP_HALT, 8'h00));
        put(0, OP_PUSH, 8'h00);
        put(1, OP_JZ, 8'd4);
        put(2, OP_PUSH, 8'hAA);
        put(3, OP_STORE, 8'd5);
        put(4, OP_PUSH, 8'h55);
        put(5, OP_STORE, 8'd5);
        put(6, OP_HALT, 8'h00);
        expect_wr(8'd5, 8'h55);
        run(20, cyc);
        check("jz_mem5", 32'(dut.memory0.mem[5]), 32'h55);
        check("jz_cycles", 32'(cyc), 5);
        check("jz_sp", 32'(dut.sp), 0);

        // Countdown loop: body runs 3 times, stores 3,2,1 then the final 0.
        reset_dut();
        load_loop();
        expect_loop();
        run(100, cyc);
        check("loop_cycles", 32'(cyc), 21);
        check("loop_mem2", 32'(dut.memory0.mem[2]), 0);
        check("loop_sp", 32'(dut.sp), 0);
        check("loop_halted", 32'(dut.ifidc0.halted), 1);
        check("loop_sb_drain", 32'(exp_q.size()), 0);

        // Asynchronous reset after 8 instructions, then a full rerun.
        reset_dut();
        load_loop();
        expect_loop();
        repeat (8) @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        check("midrst_pc", 32'(dut.ifidc0.pc), 0);
        check("midrst_sp", 32'(dut.sp), 0);
        check("midrst_halted", 32'(dut.ifidc0.halted), 0);
        check("midrst_stack_err", 32'(dut.ifidc0.stack_err), 0);
        check("midrst_mem2_kept", 32'(dut.memory0.mem[2]), 2);
        check("midrst_writes_left", 32'(exp_q.size()), 2);
        @(posedge clk);
        #1;
        check("midrst_hold_pc", 32'(dut.ifidc0.pc), 0);
        exp_q.delete();
        expect_loop();
        @(negedge clk);
        #1 rstn = 1'b1;
        run(100, cyc);
        check("rerun_cycles", 32'(cyc), 21);
        check("rerun_mem2", 32'(dut.memory0.mem[2]), 0);
        check("rerun_sp", 32'(dut.sp), 0);
        check("rerun_sb_drain", 32'(exp_q.size()), 0);

        // Nine pushes into an eight-deep stack.
        reset_dut();
        fill(ins(OP_HALT, 8'h00));
        for (int i = 0; i < 9; i++) put(i, OP_PUSH, 8'(i + 1));
        put(9, OP_HALT, 8'h00);
        run(30, cyc);
        check("ovf_sp", 32'(dut.sp), 8);
        check("ovf_top_kept", 32'(dut.stk[7]), 8);
        check("ovf_halted", 32'(dut.ifidc0.halted), 1);
`ifdef CPU_STACK_GUARD_EN
        check("ovf_stack_err", 32'(dut.ifidc0.stack_err), 1);
        check("ovf_pc", 32'(dut.ifidc0.pc), 8);
        check("ovf_cycles", 32'(cyc), 9);
`else
        check("ovf_stack_err", 32'(dut.ifidc0.stack_err), 0);
        check("ovf_pc", 32'(dut.ifidc0.pc), 10);
        check("ovf_cycles", 32'(cyc), 10);
`endif

        // Running off the end of a NOP-only store.
        reset_dut();
        fill(ins(OP_NOP, 8'h00));
        run(40, cyc);
        check("nop_pc", 32'(dut.ifidc0.pc), 20);
        check("nop_halted", 32'(dut.ifidc0.halted), 1);
        check("nop_cycles", 32'(cyc), 21);

        // Jump beyond the store halts on the following fetch.
        reset_dut();
        fill(ins(OP_NOP, 8'h00));
        put(0, OP_JMP, 8'd25);
        run(10, cyc);
        check("jmp25_pc", 32'(dut.ifidc0.pc), 25);
        check("jmp25_halted", 32'(dut.ifidc0.halted), 1);
        check("jmp25_cycles", 32'(cyc), 2);

        // Halted state stays frozen across further clocks.
        repeat (3) @(posedge clk);
        #1;
        check("frozen_pc", 32'(dut.ifidc0.pc), 25);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/cpu.md
# cpu

Single-cycle 8-bit stack-machine processor and the top-level DUT of the processor testbench. It holds its own instruction store and data memory; both are preloaded by the bench through hierarchical `$readmemb`. It executes one instruction per clock and halts on HALT, on fetch past the end of the program, or on a stack error when the stack guard is compiled in.

## Interface
- WORD_LEN, 8: data-memory word width; must equal DATA_LEN.
- DATA_LEN, 8: data path and stack entry width.
- ADDR_LEN, 8: data/jump address width; operand field width.
- MEM_SIZE, 256: data-memory words; must be ≤ 2^ADDR_LEN.
- STACK_DEPTH, 8: operand stack entries.
- INST_LEN, 12: instruction width, {opcode[11:8], operand[7:0]}.
- INST_CAP, 20: instruction-store entries.
- clk  input  1  rising-edge clock; one clock, nothing else clocked.
- rstn  input  1  reset, asynchronous and active-low.
- No other ports. Observable state is internal: pc (ADDR_LEN), sp (0..STACK_DEPTH), halted, stack_err.
- Required hierarchy: instance `memory0` with array `mem[0:MEM_SIZE-1]` of WORD_LEN bits, and instance `ifidc0` with array `inst_mem[0:INST_CAP-1]` of INST_LEN bits.

## Operation
- Opcodes: 0 NOP; 1 PUSH imm; 2 LOAD a (push mem[a]); 3 STORE a (pop to mem[a]).
- Opcodes 4–8 pop b, pop a, push result: 4 ADD a+b; 5 SUB a−b; 6 AND; 7 OR; 8 XOR.
- 9 NOT replaces top with ~top. A DUP pushes a copy of top.
- B JMP a sets pc=a. C JZ a pops top and jumps if it was 0. D JNZ a pops top and jumps if it was nonzero.
- E is reserved and behaves as NOP. F HALT.
- Arithmetic is modulo 2^DATA_LEN. There are no flags beyond halted/stack_err.
- Non-jumping instructions set pc=pc+1.
- If pc ≥ INST_CAP at fetch, halted sets and nothing executes.
- Address ≥ MEM_SIZE: LOAD pushes 0 and STORE discards the value (sp still decrements).
- While halted, all state is frozen until reset.
- Stack error (push when sp==STACK_DEPTH, or fewer entries than the op consumes): behaviour is set by the Configuration section.

## Timing
- Instruction fetch and data-memory read are combinational.
- Stack, pc, sp, halted and the memory write all update on the same rising edge.
- Each instruction takes exactly 1 cycle, and its results are visible after that edge.
- rstn low immediately forces pc=0, sp=0, halted=0, stack_err=0.
- Stack contents, `mem` and `inst_mem` are not reset; preloaded contents survive reset.
- Reset takes effect asynchronously mid-program. Execution resumes at pc=0 on the first rising edge after rstn rises.
- A STORE to an address is visible to a LOAD from that address in the next instruction.

## Configuration
- CPU_STACK_GUARD_EN defined:
  - A stack error sets stack_err=1 and halted=1.
  - The faulting instruction has no effect, and pc stays at it.
- CPU_STACK_GUARD_EN undefined:
  - A push on full is discarded with sp unchanged.
  - Missing pop operands read as 0 and sp saturates at 0.
  - Execution continues, and stack_err stays 0.

## Structure
- Shared package `cpu_pkg` holds:
  - the opcode enumeration (4 bits);
  - field-position constants OPC_MSB=11, OPC_LSB=8, OPR_MSB=7;
  - the default parameter values.
- Sub-module `memory` (instance memory0) is the data memory: combinational read, synchronous write.
- `ifidc` (instance ifidc0) contains inst_mem, pc, and decode/control.
- The stack and ALU live in the top level.

## Test plan
- PUSH 5, PUSH 3, ADD, STORE 0x10, HALT → mem[0x10]=8, sp=0, halted=1 after 5 cycles.
- Preload mem[0]=0xF0; LOAD 0, PUSH 0x20, SUB, STORE 1 → mem[1]=0xD0. PUSH 1, PUSH 2, SUB → top=0xFF (wrap).
- PUSH 3 then a loop of STORE 2, LOAD 2, PUSH 1, SUB, DUP, JNZ back → body runs 3 times, final mem[2]=0, halted at HALT.
- Pulse rstn low while the loop is running → pc=0, sp=0, halted=0 during low, with mem contents retained; the program reruns identically.
- 9 consecutive PUSH:
  - with CPU_STACK_GUARD_EN → stack_err=1, halted=1, pc=8, sp=8;
  - without it → sp=8, the 9th value is discarded, and execution continues.
- inst_mem all NOP (20 entries) → halted=1 once pc=20; JMP 25 → halted the next cycle.
